// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and watchdog sizing for dmem_arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1023;

  // Wide enough to hold the TIMEOUT value itself, since the limit is compared against count+1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin picker with a last-grant register
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_o
);

  logic last_grant_q;

  // A lone requester always wins; on a tie the lane not granted last time wins.
  always_comb begin
    gnt_o = req_i[1];
    if (req_i == 2'b11) gnt_o = ~last_grant_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (update_i) begin
      last_grant_q <= gnt_o;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one variable-latency data memory between two load/store lanes
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  state_e            state_q;
  logic              lane_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              done0_q, done1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              busy_q, mem_rd_en_q, mem_wr_en_q;

  logic              gnt;
  logic              grant_en;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rsp_data;
  logic              limit_hit;

  assign grant_en  = (state_q == IDLE) && (req0 || req1);
  assign sel_we    = gnt ? we1 : we0;
  assign sel_addr  = gnt ? addr1 : addr0;
  assign sel_wdata = gnt ? wdata1 : wdata0;
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign limit_hit = (cnt_d == CNT_W'(TIMEOUT));
  // Writes and timeouts return zero data; mem_ready takes priority over the limit.
  assign rsp_data  = (mem_ready && !we_q) ? mem_rdata : '0;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    ({req1, req0}),
    .update_i (grant_en),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lane_q      <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
    end else begin
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            lane_q      <= gnt;
            we_q        <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_rd_en_q <= ~sel_we;
            mem_wr_en_q <= sel_we;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (mem_ready || limit_hit) begin
            state_q <= RESP;
            if (lane_q) begin
              done1_q  <= 1'b1;
              err1_q   <= ~mem_ready;
              rdata1_q <= rsp_data;
            end else begin
              done0_q  <= 1'b1;
              err0_q   <= ~mem_ready;
              rdata0_q <= rsp_data;
            end
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single-ported, variable-latency `data_memory_delay` between the two load/store lanes of the superscalar pipeline. It owns the memory's `rd_en`/`wr_en` strobes and waits on the memory's `ready` pulse. It returns per-lane completion with read data, and it resolves simultaneous requests round-robin. A watchdog terminates any access whose `ready` never arrives.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 1023, maximum WAIT cycles before an access is aborted (≥1).

Ports. Lane ports come as a 0/1 pair, one line per pair; lane 1 is identical to lane 0.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held high with a stable command until `done` of that lane.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `done0` / `done1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid while `done` is high, 0 otherwise.
- `err0` / `err1`  out  1  high with `done` if the access timed out.
- `busy`  out  1  high in any state other than IDLE.
- `mem_rd_en`, `mem_wr_en`  out  1  single-cycle memory strobes.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_ready`  in  1  memory completion pulse, for reads and writes.
- `mem_rdata`  in  DATA_W  valid in the `mem_ready` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req` is high: pick the winner, latch its `we`/`addr`/`wdata`/lane id, go to ISSUE.
  - Arbitration: a single requester always wins. If both request, the lane ≠ `last_grant` wins. `last_grant` updates on every grant.
- **ISSUE**: for exactly one cycle, drive `mem_rd_en` or `mem_wr_en` with the latched `mem_addr`/`mem_wdata`. Clear the timeout counter. Go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `mem_ready`: register `mem_rdata`, or 0 for a write. Go to RESP with `err` = 0.
  - If the counter reaches `TIMEOUT` with no `mem_ready`: go to RESP with `err` = 1 and data 0.
  - If `mem_ready` and the counter limit hit in the same cycle, `mem_ready` wins.
- **RESP**: pulse `done`/`err`/`rdata` on the granted lane only, then go to IDLE.
- A lane still holding `req` in the cycle after its `done` is treated as a new request.
- `mem_ready` outside WAIT (stray or late after a timeout) is ignored and never produces `done`.
- The `req` of the non-granted lane is not sampled until the next IDLE. The loser is not latched and keeps holding.

## Timing
- Reset (asynchronous, `reset_n` low) forces:
  - state IDLE and `last_grant` = 1, so lane 0 wins the first tie;
  - counter 0 and all latched command regs 0;
  - every output 0: `done*`, `err*`, `rdata*`, `busy`, `mem_rd_en`, `mem_wr_en`, `mem_addr`, `mem_wdata`.
- Reset mid-access drops the access silently; no `done` is issued.
- Memory-side outputs are registered, and `mem_addr`/`mem_wdata` hold their values through WAIT.
- Per-access timing, with the request seen in IDLE at cycle 0:
  - strobe at cycle 1;
  - memory latency L cycles → `mem_ready` at cycle 1+L;
  - `done` at cycle 2+L.
- Next IDLE sample is at cycle 3+L, so there is one bubble between back-to-back accesses.
- Timeout: `done`+`err` at cycle 1 + `TIMEOUT` + 1.
- `busy` is high from cycle 1 through the RESP cycle.

## Structure
- Shared package `dmem_pkg` holds:
  - the state encoding `IDLE=2'd0`, `ISSUE=2'd1`, `WAIT=2'd2`, `RESP=2'd3`;
  - the default `TIMEOUT`;
  - `$clog2`-derived counter width, `$clog2(TIMEOUT+1)`.
- One natural sub-module: `rr_arb2`, a two-requester round-robin picker with a `last_grant` register and an update-enable input.
- The FSM, command latch and watchdog stay in `dmem_arbiter`.

## Test plan
- **Lone read**: `req0`=1, `we0`=0, `addr0`=8'h2A, memory returns 32'h0000_0ABC after L=30.
  - Expect one `mem_rd_en` pulse at cycle 1 with `mem_addr`=0x2A.
  - Expect `done0`=1 with `rdata0`=0xABC at cycle 32; lane 1 outputs stay 0.
- **Write then read-back**: lane 1 writes 0x5A5 to 0x10, then reads 0x10.
  - Expect the write `done1` with `rdata1`=0 and `err1`=0.
  - Expect the read `done1` with `rdata1`=0x5A5.
- **Simultaneous requests after reset**: both `req` high.
  - Expect lane 0 served first.
  - Expect lane 1 strobed at the next IDLE+1, i.e. the cycle after lane 0's `done` plus one.
  - Repeat the tie: lane 1 wins, confirming alternation.
- **Timeout**: memory never asserts `ready`, `TIMEOUT`=16.
  - Expect `done0`=`err0`=1 and `rdata0`=0 at cycle 18.
  - A later stray `mem_ready` produces no `done`.
- **Reset mid-WAIT**: assert `reset_n`=0 during WAIT.
  - Expect all outputs 0 immediately and no `done` afterwards.
  - Expect the next `req0` served normally, with lane 0 winning a tie.
- **`mem_ready` coincident with the timeout limit**: expect a normal completion with `err` = 0 and the memory's `rdata`.
